// File: rtl/sound_pkg.sv
// Shared sound constants: clock, note width, note pitches and effect type codes.
package sound_pkg;

  localparam int CLK_FREQ = 50_000_000;
  localparam int NOTE_W   = 14;

  // Note pitches in Hz (rounded to the nearest integer).
  localparam logic [NOTE_W-1:0] B3 = 14'd247;
  localparam logic [NOTE_W-1:0] F4 = 14'd349;
  localparam logic [NOTE_W-1:0] G5 = 14'd784;
  localparam logic [NOTE_W-1:0] C6 = 14'd1047;
  localparam logic [NOTE_W-1:0] D6 = 14'd1175;
  localparam logic [NOTE_W-1:0] E6 = 14'd1319;
  localparam logic [NOTE_W-1:0] F6 = 14'd1397;
  localparam logic [NOTE_W-1:0] G6 = 14'd1568;
  localparam logic [NOTE_W-1:0] B6 = 14'd1976;
  localparam logic [NOTE_W-1:0] C7 = 14'd2093;

  // Sound effect classes shared between the sequencer and the synth.
  typedef enum logic [1:0] {
    TYPE_START   = 2'd0,
    TYPE_DROP    = 2'd1,
    TYPE_ERROR   = 2'd2,
    TYPE_VICTORY = 2'd3
  } sfx_type_e;

endpackage

// File: rtl/tone_synth_if.sv
// Sequencer-to-synth link: requested note and enable in, buzzer and busy out.
interface tone_synth_if #(
  parameter int NOTE_W = sound_pkg::NOTE_W
);
  logic [NOTE_W-1:0] note;
  logic              enable;
  logic              buzzer_out;
  logic              busy;

  modport master (output note, enable, input buzzer_out, busy);
  modport slave  (input note, enable, output buzzer_out, busy);
endinterface

// File: rtl/tone_synth_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; start while busy restarts.
module seq_divider #(
  parameter int DIV_W = 25,
  parameter int DSR_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DSR_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [DSR_W-1:0] rem;
  logic [DSR_W-1:0] dsr;
  logic [DSR_W:0]   trial;

  // Quotient register doubles as the dividend shift register.
  assign trial = {rem, quotient[DIV_W-1]};

  // Iteration: abort beats start, start beats an ongoing step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else if (start) begin
        busy     <= 1'b1;
        cnt      <= CNT_W'(DIV_W);
        quotient <= dividend;
        rem      <= '0;
        dsr      <= divisor;
      end else if (busy) begin
        if (trial >= {1'b0, dsr}) begin
          rem      <= DSR_W'(trial - {1'b0, dsr});
          quotient <= {quotient[DIV_W-2:0], 1'b1};
        end else begin
          rem      <= trial[DSR_W-1:0];
          quotient <= {quotient[DIV_W-2:0], 1'b0};
        end
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/tone_synth.sv
// Note (Hz) to 50%-duty square wave; new pitches swap in only at toggle boundaries.
module tone_synth #(
  parameter int CLK_FREQ = sound_pkg::CLK_FREQ,
  parameter int NOTE_W   = sound_pkg::NOTE_W,
  parameter int MIN_NOTE = 20
) (
  input logic         clk,
  input logic         rst,
  tone_synth_if.slave bus
);
  import sound_pkg::*;

  localparam int DIV_W = $clog2(CLK_FREQ/2 + 1);

  logic [NOTE_W-1:0] latched_note;
  logic              en_q, cap, silent_cap;
  logic              div_busy, div_done;
  logic [DIV_W-1:0]  quot, hp_q;
  logic [DIV_W-1:0]  half_period, phase_cnt, pending_hp;
  logic              square, pend_vld;
  logic [DIV_W-1:0]  hp_n, cnt_n, php_n;
  logic              sq_n, pend_n;

  // New request: note differs from the latched one, or first enabled cycle.
  assign cap        = bus.enable && (!en_q || bus.note != latched_note);
  assign silent_cap = cap && (bus.note < NOTE_W'(MIN_NOTE));
  // Notes above CLK_FREQ/2 divide to zero; play the fastest possible tone instead.
  assign hp_q       = (quot == '0) ? DIV_W'(1) : quot;
  assign bus.busy   = div_busy;

  seq_divider #(.DIV_W(DIV_W), .DSR_W(NOTE_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (cap && !silent_cap),
    .abort    (!bus.enable || silent_cap),
    .dividend (DIV_W'(CLK_FREQ/2)),
    .divisor  (bus.note),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quot)
  );

  // Next tone state: silence, pending capture, and boundary-aligned period swap.
  always_comb begin
    hp_n   = half_period;
    cnt_n  = phase_cnt;
    sq_n   = square;
    pend_n = pend_vld;
    php_n  = pending_hp;
    if (!bus.enable || silent_cap) begin
      hp_n   = '0;
      cnt_n  = '0;
      sq_n   = 1'b0;
      pend_n = 1'b0;
    end else begin
      if (cap) pend_n = 1'b0;
      // A result finishing on the same cycle as a new request is stale.
      if (div_done && !cap) begin
        pend_n = 1'b1;
        php_n  = hp_q;
      end
      if (half_period == '0) begin
        if (pend_n) begin
          hp_n   = php_n;
          cnt_n  = '0;
          sq_n   = 1'b1;
          pend_n = 1'b0;
        end
      end else if (phase_cnt == half_period - DIV_W'(1)) begin
        cnt_n = '0;
        sq_n  = ~square;
        if (pend_n) begin
          hp_n   = php_n;
          pend_n = 1'b0;
        end
      end else begin
        cnt_n = phase_cnt + DIV_W'(1);
      end
    end
  end

  // Tone state registers; buzzer is registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q           <= 1'b0;
      latched_note   <= '0;
      half_period    <= '0;
      phase_cnt      <= '0;
      square         <= 1'b0;
      pending_hp     <= '0;
      pend_vld       <= 1'b0;
      bus.buzzer_out <= 1'b0;
    end else begin
      en_q <= bus.enable;
      if (!bus.enable)  latched_note <= '0;
      else if (cap)     latched_note <= bus.note;
      half_period    <= hp_n;
      phase_cnt      <= cnt_n;
      square         <= sq_n;
      pending_hp     <= php_n;
      pend_vld       <= pend_n;
      bus.buzzer_out <= bus.enable & sq_n & (hp_n != '0);
    end
  end
endmodule

// File: tb/tb_tone_synth.sv
// Self-checking bench for tone_synth: directed pitch scenarios plus random note traffic.
module tb_tone_synth;
  import sound_pkg::*;

  localparam int CF   = 1_000_000;
  localparam int DW   = 19;
  localparam int MINN = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tone_synth_if #(.NOTE_W(NOTE_W)) bus();

  tone_synth #(.CLK_FREQ(CF), .NOTE_W(NOTE_W), .MIN_NOTE(MINN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: timestamps of requests and half-cycle starts, in edge units.
  int m_edge, m_lat, m_req, m_req_hp, m_pend, m_hp, m_seg;
  bit m_enq, m_sq;
  bit cur_en;
  int cur_note;

  function automatic void m_reset();
    m_edge = 0; m_lat = 0; m_req = -1; m_req_hp = 0; m_pend = -1;
    m_hp = 0; m_seg = 0; m_enq = 1'b0; m_sq = 1'b0;
  endfunction

  function automatic void m_upd(input bit en, input int nt);
    bit cap, sil;
    m_edge++;
    sil = 1'b0;
    if (!en) begin
      m_hp = 0; m_sq = 1'b0; m_pend = -1; m_req = -1; m_lat = 0;
    end else begin
      cap = !m_enq || (nt != m_lat);
      sil = cap && (nt < MINN);
      if (cap) begin
        m_lat  = nt;
        m_pend = -1;
        if (sil) begin
          m_hp = 0; m_sq = 1'b0; m_req = -1;
        end else begin
          m_req    = m_edge;
          m_req_hp = (CF/2) / nt;
          if (m_req_hp == 0) m_req_hp = 1;
        end
      end else if (m_req >= 0 && m_edge == m_req + DW + 1) begin
        m_pend = m_req_hp;
        m_req  = -1;
      end
      if (!sil) begin
        if (m_hp == 0) begin
          if (m_pend >= 0) begin
            m_hp = m_pend; m_pend = -1; m_sq = 1'b1; m_seg = m_edge;
          end
        end else if (m_edge - m_seg == m_hp) begin
          m_sq  = !m_sq;
          m_seg = m_edge;
          if (m_pend >= 0) begin
            m_hp = m_pend; m_pend = -1;
          end
        end
      end
    end
    m_enq = en;
  endfunction

  function automatic int exp_busy();
    return (m_req >= 0 && m_edge <= m_req + DW - 1) ? 1 : 0;
  endfunction

  function automatic int exp_buz();
    return (m_enq && m_sq && m_hp != 0) ? 1 : 0;
  endfunction

  task automatic set_in(input bit en, input int nt);
    cur_en   = en;
    cur_note = nt;
  endtask

  task automatic step();
    @(negedge clk);
    bus.enable = cur_en;
    bus.note   = NOTE_W'(cur_note);
    @(posedge clk);
    m_upd(cur_en, cur_note);
    #1;
    chk("busy", bus.busy, exp_busy());
    chk("buzzer", bus.buzzer_out, exp_buz());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Steps until buzzer goes high; k counts steps taken, -1 on timeout.
  task automatic rise_after(output int k);
    k = -1;
    for (int i = 1; i <= 3000; i++) begin
      step();
      if (bus.buzzer_out === 1'b1) begin
        k = i;
        return;
      end
    end
  endtask

  // Length of the current buzzer level run; optionally swaps note mid-run.
  task automatic seg_len(output int len, input int chg_at, input int chg_note);
    logic lvl;
    lvl = bus.buzzer_out;
    len = 1;
    for (int i = 0; i < 5000; i++) begin
      if (len == chg_at) cur_note = chg_note;
      step();
      if (bus.buzzer_out !== lvl) return;
      len++;
    end
    len = -1;
  endtask

  // Asynchronous reset away from the clock edge; outputs must clear immediately.
  task automatic async_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_buzzer", bus.buzzer_out, 0);
    m_reset();
    bus.enable = 1'b0;
    set_in(1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, len;
    bus.enable = 1'b0;
    bus.note   = '0;
    set_in(1'b0, 0);
    m_reset();
    repeat (2) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_buzzer", bus.buzzer_out, 0);
    rst = 1'b0;

    // 1000 Hz from silence: first rise 21 cycles after the request.
    set_in(1'b1, 1000);
    rise_after(k);
    chk("first_rise", k, 21);
    seg_len(len, -1, 0); chk("hi_1000", len, 500);
    seg_len(len, -1, 0); chk("lo_1000", len, 500);
    // Switch to C6 100 cycles into a high phase: that phase must still last 500.
    seg_len(len, 100, C6); chk("hi_keep", len, 500);
    seg_len(len, -1, 0); chk("lo_1047", len, 477);
    seg_len(len, -1, 0); chk("hi_1047", len, 477);

    // B3 takes over at the next boundary, then a sub-threshold note silences it.
    set_in(1'b1, B3);
    run(60);
    seg_len(len, -1, 0);
    seg_len(len, -1, 0); chk("hp_247", len, 2024);
    if (bus.buzzer_out !== 1'b1) seg_len(len, -1, 0);
    run(10);
    set_in(1'b1, 10);
    step();
    chk("silence_now", bus.buzzer_out, 0);
    run(50);

    // Restart during busy: only the second note's period is ever applied.
    set_in(1'b1, 1000);
    step();
    set_in(1'b1, C7);
    rise_after(k);
    chk("rise_2093", k, 21);
    seg_len(len, -1, 0); chk("hi_2093", len, 238);

    // Enable drop and re-enable with the same note forces a full recompute.
    set_in(1'b1, G6);
    run(40);
    run(300);
    set_in(1'b0, G6);
    step();
    chk("drop_buzzer", bus.buzzer_out, 0);
    chk("drop_busy", bus.busy, 0);
    set_in(1'b1, G6);
    step();
    chk("reen_busy", bus.busy, 1);
    rise_after(k);
    chk("reen_rise", k, 20);
    seg_len(len, -1, 0); chk("hi_1568", len, 318);

    // Reset mid-division, then mid-high-phase.
    set_in(1'b1, G5);
    run(5);
    async_rst();
    set_in(1'b1, G5);
    rise_after(k);
    chk("rise_784", k, 21);
    run(100);
    async_rst();
    set_in(1'b1, G5);
    rise_after(k);
    chk("rise_784b", k, 21);
    seg_len(len, -1, 0); chk("hi_784", len, 637);

    // Random traffic checked every cycle against the model.
    for (int it = 0; it < 60; it++) begin
      int r, hold;
      r = $urandom_range(0, 19);
      if (r == 0)      async_rst();
      else if (r < 3)  set_in(1'b0, cur_note);
      else if (r < 5)  set_in(1'b1, $urandom_range(0, 25));
      else             set_in(1'b1, $urandom_range(400, 8000));
      if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, 4);
      else                           hold = $urandom_range(20, 700);
      run(hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
